// File: rtl/game_sprite_motion_if.sv
// ============================================================================
// Module      : game_sprite_motion_if
// Description : Control/status bundle for the sprite motion engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_sprite_motion_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int D_WIDTH = 4
);
    logic               sprite_write_xy;
    logic               sprite_write_dxy;
    logic               sprite_enable_update;
    logic [X_WIDTH-1:0] sprite_write_x;
    logic [Y_WIDTH-1:0] sprite_write_y;
    logic [D_WIDTH-1:0] sprite_write_dx;
    logic [D_WIDTH-1:0] sprite_write_dy;
    logic [X_WIDTH-1:0] sprite_x;
    logic [Y_WIDTH-1:0] sprite_y;
    logic               sprite_within_screen;
    logic               sprite_step;

    modport master (
        output sprite_write_xy, sprite_write_dxy, sprite_enable_update,
        output sprite_write_x, sprite_write_y, sprite_write_dx, sprite_write_dy,
        input  sprite_x, sprite_y, sprite_within_screen, sprite_step
    );

    modport slave (
        input  sprite_write_xy, sprite_write_dxy, sprite_enable_update,
        input  sprite_write_x, sprite_write_y, sprite_write_dx, sprite_write_dy,
        output sprite_x, sprite_y, sprite_within_screen, sprite_step
    );
endinterface

`default_nettype wire

// File: rtl/game_sprite_motion.sv
// ============================================================================
// Module      : game_sprite_motion
// Description : Sprite position integrator stepping x/y by a signed velocity
//               once every UPDATE_PERIOD clocks, with on-screen detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sprite_motion #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int D_WIDTH       = 4,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SPRITE_SIZE   = 8,
    parameter int UPDATE_PERIOD = 2**20
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    game_sprite_motion_if.slave    bus
);
    localparam int                 CNT_W      = (UPDATE_PERIOD > 2) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [X_WIDTH-1:0] c_X_MAX    = X_WIDTH'(SCREEN_WIDTH - SPRITE_SIZE);
    localparam logic [Y_WIDTH-1:0] c_Y_MAX    = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_SIZE);

    logic [CNT_W-1:0]   r_cnt;
    logic [X_WIDTH-1:0] r_x;
    logic [Y_WIDTH-1:0] r_y;
    logic [D_WIDTH-1:0] r_dx;
    logic [D_WIDTH-1:0] r_dy;
    logic               r_step;

    logic               w_strobe;
    logic               w_fire;
    logic [X_WIDTH-1:0] w_dx_ext;
    logic [Y_WIDTH-1:0] w_dy_ext;

    assign w_strobe = (r_cnt == c_CNT_LAST);
    // A position load wins over a coincident step; that step is simply dropped.
    assign w_fire   = w_strobe && bus.sprite_enable_update && !bus.sprite_write_xy;
    assign w_dx_ext = X_WIDTH'($signed(r_dx));
    assign w_dy_ext = Y_WIDTH'($signed(r_dy));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_strobe) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= w_fire;
            if (bus.sprite_write_xy) begin
                r_x <= bus.sprite_write_x;
                r_y <= bus.sprite_write_y;
            end else if (w_fire) begin
                r_x <= r_x + w_dx_ext;
                r_y <= r_y + w_dy_ext;
            end
            // The step above reads the old velocity even when a new one lands now.
            if (bus.sprite_write_dxy) begin
                r_dx <= bus.sprite_write_dx;
                r_dy <= bus.sprite_write_dy;
            end
        end
    end

    assign bus.sprite_x             = r_x;
    assign bus.sprite_y             = r_y;
    assign bus.sprite_step          = r_step;
    assign bus.sprite_within_screen = (r_x <= c_X_MAX) && (r_y <= c_Y_MAX);

endmodule

`default_nettype wire
